// File: rtl/stripe_arbiter.sv
// Two-requester round-robin packet arbiter feeding a two-lane striping datapath.
// Odd-length packets are followed by one PAD byte so every packet starts on lane 0.
module stripe_arbiter #(
   parameter logic [7:0]  PAD_BYTE = 8'hBC,
   parameter int unsigned IDLE_GAP = 0
) (
   input  logic       clk_2f,
   input  logic       reset,
   input  logic       valid_a,
   input  logic [7:0] data_a,
   input  logic       last_a,
   output logic       ready_a,
   input  logic       valid_b,
   input  logic [7:0] data_b,
   input  logic       last_b,
   output logic       ready_b,
   output logic       valid_out,
   output logic [7:0] data_out,
   output logic       lane_out,
   output logic       owner,
   output logic       busy
);

   typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, PAD, GAP} state_t;

   localparam state_t     AFTER_PKT = (IDLE_GAP != 0) ? GAP : IDLE;
   localparam logic [2:0] GAP_LAST  = 3'(IDLE_GAP - 1);

   state_t     state;
   logic       par;
   logic       rr_last;
   logic [2:0] gap_cnt;

   logic       src_valid;
   logic       src_last;
   logic [7:0] src_data;

   assign src_valid = (state == SEND_B) ? valid_b : valid_a;
   assign src_last  = (state == SEND_B) ? last_b  : last_a;
   assign src_data  = (state == SEND_B) ? data_b  : data_a;

   // Ready is masked during reset so a source never sees a handshake on an aborted packet.
   assign ready_a = (state == SEND_A) && !reset;
   assign ready_b = (state == SEND_B) && !reset;
   assign busy    = (state != IDLE);

   always_ff @(posedge clk_2f) begin
      if (reset) begin
         state     <= IDLE;
         par       <= 1'b0;
         rr_last   <= 1'b1;
         gap_cnt   <= 3'd0;
         valid_out <= 1'b0;
         data_out  <= 8'h00;
         lane_out  <= 1'b0;
         owner     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               valid_out <= 1'b0;
               // rr_last == 1 means B was served last, so A wins a tie.
               if (valid_a && (!valid_b || rr_last)) begin
                  state <= SEND_A;
                  owner <= 1'b0;
               end else if (valid_b) begin
                  state <= SEND_B;
                  owner <= 1'b1;
               end
            end
            SEND_A, SEND_B: begin
               if (src_valid) begin
                  valid_out <= 1'b1;
                  data_out  <= src_data;
                  lane_out  <= par;
                  par       <= ~par;
                  if (src_last) begin
                     rr_last <= (state == SEND_B);
                     gap_cnt <= 3'd0;
                     state   <= !par ? PAD : AFTER_PKT;
                  end
               end else begin
                  valid_out <= 1'b0;
               end
            end
            PAD: begin
               valid_out <= 1'b1;
               data_out  <= PAD_BYTE;
               lane_out  <= 1'b1;
               par       <= 1'b0;
               gap_cnt   <= 3'd0;
               state     <= AFTER_PKT;
            end
            GAP: begin
               valid_out <= 1'b0;
               if (gap_cnt == GAP_LAST) begin
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 3'd1;
               end
            end
            default: begin
               valid_out <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/stripe_arbiter.md
STRIPE_ARBITER -- requirements
Module: stripe_arbiter

Interface
REQ-001 SHALL have parameter PAD_BYTE, default 8'hBC: filler byte used to realign lanes after an odd-length packet.
REQ-002 SHALL have parameter IDLE_GAP, default 0: number of extra idle cycles inserted between packets (0..7).
REQ-003 SHALL have port clk_2f  input  1  single clock; all logic is rising-edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports valid_a  input  1, data_a  input  8, last_a  input  1: requester A byte stream; last_a marks the final byte of a packet.
REQ-006 SHALL have port ready_a  output  1: A byte accepted on a clock edge where valid_a && ready_a.
REQ-007 SHALL have ports valid_b, data_b, last_b, ready_b, with the same widths and meaning for requester B.
REQ-008 SHALL have port valid_out  output  1: a byte for the striping datapath is present.
REQ-009 SHALL have port data_out  output  8: byte for the striping datapath.
REQ-010 SHALL have port lane_out  output  1: lane (0/1) the current data_out byte lands on.
REQ-011 SHALL have port owner  output  1: 0 = A, 1 = B; source of the current or last granted packet.
REQ-012 SHALL have port busy  output  1: high in any state other than IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, SEND_A, SEND_B, PAD and GAP.
REQ-014 IDLE transitions:
- only valid_a: go to SEND_A.
- only valid_b: go to SEND_B.
- both valid: grant the requester not equal to rr_last (round-robin).
- neither valid: stay in IDLE.
REQ-015 The grant decision SHALL take one cycle.
- Neither ready is asserted in IDLE.
REQ-016 ready_a SHALL be combinational and equal to (state==SEND_A); ready_b likewise for SEND_B.
- A non-granted requester is never readied mid-packet.
REQ-017 On an accepted byte (valid && ready), the next edge SHALL register:
- data_out = the byte, valid_out = 1.
- lane_out = par; then par toggles.
- Latency: input to output is 1 cycle.
REQ-018 A granted source holding valid low SHALL cause, on the next edge:
- valid_out = 0;
- data_out, lane_out and par held;
- state held (stall).
REQ-019 On an accepted byte with last asserted:
- rr_last updates to the granting source.
- If par after the toggle is 1 (odd count in lane pair), next state is PAD.
- Otherwise next state is GAP when IDLE_GAP>0, else IDLE.
REQ-020 PAD SHALL last one cycle and register data_out = PAD_BYTE, valid_out = 1, lane_out = 1.
- par returns to 0.
- Next state is GAP or IDLE per REQ-019.
REQ-021 GAP SHALL count IDLE_GAP cycles with a 3-bit counter, holding valid_out = 0, then return to IDLE.
- The counter clears on entry.
REQ-022 In IDLE and GAP, valid_out SHALL be 0.
REQ-023 Every packet SHALL start on lane 0 (par == 0 at first byte).
REQ-024 owner SHALL update on the transition out of IDLE and hold until the next grant.
REQ-025 A new request arriving during PAD, GAP or another packet SHALL wait.
- No preemption.
- Arbitration happens only in IDLE.

Reset
REQ-026 While reset is high at a clock edge, the block SHALL force:
- state = IDLE, par = 0, rr_last = 1 (A wins first tie);
- gap counter = 0;
- valid_out = 0, data_out = 8'h00, lane_out = 0, owner = 0, busy = 0;
- ready_a = ready_b = 0.
REQ-027 Reset asserted mid-packet or mid-PAD SHALL abort that packet with no PAD emitted.
- After release, arbitration restarts from IDLE.

Verification
REQ-028 The bench SHALL cover single requester:
- Stimulus: A sends 4 bytes 01,02,03,04 (last on 04).
- Required: valid_out bytes 01..04 on lanes 0,1,0,1; no PAD; back to IDLE.
REQ-029 The bench SHALL cover odd length:
- Stimulus: B sends 3 bytes AA,BB,CC.
- Required: output AA(l0), BB(l1), CC(l0), then BC(l1); owner = 1.
REQ-030 The bench SHALL cover tie:
- Stimulus: A and B both valid from reset release, 2-byte packets each, continuously requesting.
- Required: grants alternate A,B,A,B; the first grant goes to A.
REQ-031 The bench SHALL cover stall:
- Stimulus: A drops valid for 2 cycles mid-packet.
- Required: valid_out = 0 for 2 cycles; lane_out and par are not advanced; resumed byte lands on the correct lane.
REQ-032 The bench SHALL cover reset mid-packet:
- Stimulus: reset after the 1st of 3 bytes.
- Required: next edge gives valid_out = 0 and busy = 0; no PAD; the next packet starts on lane 0.
REQ-033 The bench SHALL cover gap:
- Stimulus: IDLE_GAP = 2, back-to-back A packets.
- Required: exactly 2 GAP cycles plus 1 IDLE cycle between the last byte (or PAD) and the next first byte.
